ped_signal_controller: RTL and testbench

//  Pedestrian-crossing stage downstream of the vehicle traffic light controller.

---
 rtl/ped_signal_pkg.sv | 15 +
 rtl/ped_btn_sync.sv | 29 ++
 rtl/ped_signal_controller.sv | 163 ++++++++++++++++
 tb/tb_ped_signal_controller.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ped_signal_pkg.sv
// Shared types and default timing constants for the pedestrian crossing controller.
package ped_signal_pkg;

    typedef enum logic [1:0] {
        ST_DW    = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WALK  = 2'd2,
        ST_CLEAR = 2'd3
    } ped_state_e;

    localparam int unsigned WALK_T_DEF  = 7;
    localparam int unsigned FLASH_T_DEF = 5;
    localparam int unsigned CW_DEF      = 4;

endpackage

// File: rtl/ped_btn_sync.sv
// Push-button synchroniser: two flops into the clock domain, then a one-clock
// pulse on the synchronised rising edge.
module ped_btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic rise_o
);

    logic s1_q;
    logic s2_q;
    logic s2_dly_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s2_dly_q <= 1'b0;
        end else begin
            s1_q     <= btn_i;
            s2_q     <= s1_q;
            s2_dly_q <= s2_q;
        end
    end

    // Built from flops only, so a held button yields exactly one pulse.
    assign rise_o = s2_q & ~s2_dly_q;

endmodule

// File: rtl/ped_signal_controller.sv
// Pedestrian crossing controller: grants WALK then flashing clearance inside a vehicle RED.
// Optional countdown display enabled by defining PED_COUNTDOWN_EN.
//
// state | meaning
// DW    | don't walk, no request outstanding
// WAIT  | request latched, waiting for the next vehicle red rise
// WALK  | walk lamp on, walk timer running
// CLEAR | flashing don't walk, clearance timer running
module ped_signal_controller
    import ped_signal_pkg::*;
#(
    parameter int unsigned WALK_T  = WALK_T_DEF,
    parameter int unsigned FLASH_T = FLASH_T_DEF,
    parameter int unsigned CW      = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          veh_red,
    input  logic          veh_green,
    input  logic          veh_yellow,
    input  logic          ped_btn,
    input  logic          tick,
    output logic          walk,
    output logic          dont_walk,
    output logic          req_pending,
    output logic [CW-1:0] countdown
);

    localparam logic [CW-1:0] WALK_LOAD  = CW'(WALK_T);
    localparam logic [CW-1:0] FLASH_LOAD = CW'(FLASH_T);
    localparam logic [CW-1:0] TC_ONE     = CW'(1);

    ped_state_e    state_q, state_d;
    logic [CW-1:0] timer_q, timer_d;
    logic          flash_q, flash_d;
    logic          req_q,   req_d;
    logic          red_q;
    logic          btn_rise;
    logic          red_rise;
    logic          lamp_unused;

    // Green/yellow are monitor-only; red alone decides the grant.
    assign lamp_unused = veh_green ^ veh_yellow;

    ped_btn_sync u_btn_sync (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (ped_btn),
        .rise_o (btn_rise)
    );

    assign red_rise = veh_red & ~red_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_DW;
            timer_q <= '0;
            flash_q <= 1'b0;
            req_q   <= 1'b0;
            red_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            flash_q <= flash_d;
            req_q   <= req_d;
            red_q   <= veh_red;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        flash_d = flash_q;
        req_d   = req_q;
        case (state_q)
            ST_DW: begin
                if (btn_rise) begin
                    req_d = 1'b1;
                end
                if (btn_rise || req_q) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (btn_rise) begin
                    req_d = 1'b1;
                end
                // Only a fresh red edge grants, so a walk never starts part-way into red.
                if (red_rise) begin
                    state_d = ST_WALK;
                    timer_d = WALK_LOAD;
                    req_d   = 1'b0;
                end
            end
            ST_WALK: begin
                if (!veh_red) begin
                    state_d = ST_DW;
                    timer_d = '0;
                    flash_d = 1'b0;
                end else if (tick) begin
                    if (timer_q == TC_ONE) begin
                        state_d = ST_CLEAR;
                        timer_d = FLASH_LOAD;
                        flash_d = 1'b1;
                    end else begin
                        timer_d = timer_q - TC_ONE;
                    end
                end
            end
            ST_CLEAR: begin
                if (btn_rise) begin
                    req_d = 1'b1;
                end
                if (!veh_red) begin
                    state_d = ST_DW;
                    timer_d = '0;
                    flash_d = 1'b0;
                end else if (tick) begin
                    flash_d = ~flash_q;
                    if (timer_q == TC_ONE) begin
                        state_d = (req_q || btn_rise) ? ST_WAIT : ST_DW;
                        timer_d = '0;
                        flash_d = 1'b0;
                    end else begin
                        timer_d = timer_q - TC_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_DW;
                timer_d = '0;
                flash_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        walk      = 1'b0;
        dont_walk = 1'b1;
        case (state_q)
            ST_WALK: begin
                walk      = 1'b1;
                dont_walk = 1'b0;
            end
            ST_CLEAR: begin
                dont_walk = flash_q;
            end
            default: begin
                walk      = 1'b0;
                dont_walk = 1'b1;
            end
        endcase
    end

    assign req_pending = req_q;

`ifdef PED_COUNTDOWN_EN
    assign countdown = (state_q == ST_CLEAR) ? timer_q : '0;
`else
    assign countdown = '0;
`endif

endmodule

// File: tb/tb_ped_signal_controller.sv
// Directed scoreboard bench for ped_signal_controller (default WALK_T=7, FLASH_T=5, CW=4).
module tb_ped_signal_controller;

`ifdef PED_COUNTDOWN_EN
    localparam bit CD_EN = 1'b1;
`else
    localparam bit CD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       veh_red;
    logic       veh_green;
    logic       veh_yellow;
    logic       ped_btn;
    logic       tick;
    logic       walk;
    logic       dont_walk;
    logic       req_pending;
    logic [3:0] countdown;

    typedef struct {
        string      tag;
        logic [6:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    ped_signal_controller dut (
        .clk         (clk),
        .rst         (rst),
        .veh_red     (veh_red),
        .veh_green   (veh_green),
        .veh_yellow  (veh_yellow),
        .ped_btn     (ped_btn),
        .tick        (tick),
        .walk        (walk),
        .dont_walk   (dont_walk),
        .req_pending (req_pending),
        .countdown   (countdown)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic w, input logic dw,
                              input logic rp, input logic [3:0] cd);
        sb_t e;
        e.tag = tag;
        e.exp = {w, dw, rp, (CD_EN ? cd : 4'd0)};
        sb_q.push_back(e);
    endtask

    task automatic check_out();
        sb_t        e;
        logic [6:0] obs;
        obs = {walk, dont_walk, req_pending, countdown};
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed=%b expected=entry", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed={walk,dw,req,cd}=%b expected=%b", e.tag, obs, e.exp);
            end
        end
    endtask

    // Drive tick for one clock, push the expected post-edge outputs, then compare.
    task automatic step(input string tag, input logic tk, input logic w, input logic dw,
                        input logic rp, input logic [3:0] cd);
        expect_out(tag, w, dw, rp, cd);
        tick = tk;
        cyc();
        tick = 1'b0;
        check_out();
    endtask

    task automatic set_red(input logic r);
        veh_red    = r;
        veh_green  = ~r;
        veh_yellow = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        set_red(1'b0);
        ped_btn = 1'b0;
        tick    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step("reset_state", 0, 0, 1, 0, 0);
        rst = 1'b0;
        step("idle_green", 0, 0, 1, 0, 0);

        // Press during green, then red rises.
        ped_btn = 1'b1;
        step("sync_edge1", 0, 0, 1, 0, 0);
        step("sync_edge2", 0, 0, 1, 0, 0);
        step("req_edge3", 0, 0, 1, 1, 0);
        ped_btn = 1'b0;
        step("wait_green", 1, 0, 1, 1, 0);
        set_red(1'b1);
        step("walk_entry", 0, 1, 0, 0, 0);
        step("walk_no_tick", 0, 1, 0, 0, 0);
        for (int i = 1; i <= 6; i++) step("walk_tick", 1, 1, 0, 0, 0);
        step("clear_entry", 1, 0, 1, 0, 5);
        for (int j = 1; j <= 4; j++) step("clear_flash", 1, 0, (j % 2 == 0), 0, 4'(5 - j));
        step("clear_done", 1, 0, 1, 0, 0);
        step("dw_after", 0, 0, 1, 0, 0);

        // Press mid-red: must wait for the next red rise.
        ped_btn = 1'b1;
        step("midred_e1", 0, 0, 1, 0, 0);
        step("midred_e2", 0, 0, 1, 0, 0);
        step("midred_req", 0, 0, 1, 1, 0);
        ped_btn = 1'b0;
        step("midred_wait1", 1, 0, 1, 1, 0);
        step("midred_wait2", 1, 0, 1, 1, 0);
        set_red(1'b0);
        step("red_off_wait", 0, 0, 1, 1, 0);
        set_red(1'b1);
        step("next_red_walk", 0, 1, 0, 0, 0);

        // Red drops on the third walk tick.
        step("abort_tick1", 1, 1, 0, 0, 0);
        step("abort_tick2", 1, 1, 0, 0, 0);
        set_red(1'b0);
        step("abort_tick3", 1, 0, 1, 0, 0);
        step("abort_no_clear", 1, 0, 1, 0, 0);

        // Press during clearance.
        ped_btn = 1'b1;
        step("t5_e1", 0, 0, 1, 0, 0);
        step("t5_e2", 0, 0, 1, 0, 0);
        step("t5_req", 0, 0, 1, 1, 0);
        ped_btn = 1'b0;
        set_red(1'b1);
        step("t5_walk", 0, 1, 0, 0, 0);
        for (int i = 1; i <= 6; i++) step("t5_walk_tick", 1, 1, 0, 0, 0);
        step("t5_clear", 1, 0, 1, 0, 5);
        step("t5_clr_t1", 1, 0, 0, 0, 4);
        ped_btn = 1'b1;
        step("t5_press_e1", 0, 0, 0, 0, 4);
        step("t5_press_e2", 0, 0, 0, 0, 4);
        step("t5_press_req", 0, 0, 0, 1, 4);
        ped_btn = 1'b0;
        step("t5_clr_t2", 1, 0, 1, 1, 3);
        step("t5_clr_t3", 1, 0, 0, 1, 2);
        step("t5_clr_t4", 1, 0, 1, 1, 1);
        step("t5_to_wait", 1, 0, 1, 1, 0);
        step("t5_wait_hold", 1, 0, 1, 1, 0);
        set_red(1'b0);
        step("t5_red_off", 0, 0, 1, 1, 0);
        set_red(1'b1);
        step("t5_walk2", 0, 1, 0, 0, 0);

        // Tick at terminal count and abort in the same cycle.
        for (int i = 1; i <= 6; i++) step("tc_walk_tick", 1, 1, 0, 0, 0);
        set_red(1'b0);
        step("abort_at_tc", 1, 0, 1, 0, 0);
        step("abort_stays_dw", 1, 0, 1, 0, 0);

        // Button held for 20 clocks spanning WAIT, WALK and CLEAR.
        ped_btn = 1'b1;
        step("hold_e1", 0, 0, 1, 0, 0);
        step("hold_e2", 0, 0, 1, 0, 0);
        step("hold_req", 0, 0, 1, 1, 0);
        set_red(1'b1);
        step("hold_walk", 0, 1, 0, 0, 0);
        for (int i = 1; i <= 6; i++) step("hold_walk_tick", 1, 1, 0, 0, 0);
        step("hold_clear", 1, 0, 1, 0, 5);
        repeat (9) cyc();
        ped_btn = 1'b0;
        step("hold_one_req", 0, 0, 1, 0, 5);
        for (int j = 1; j <= 4; j++) step("hold_clr", 1, 0, (j % 2 == 0), 0, 4'(5 - j));
        step("hold_done", 1, 0, 1, 0, 0);

        // Asynchronous reset in the middle of WALK.
        ped_btn = 1'b1;
        repeat (3) cyc();
        ped_btn = 1'b0;
        step("t1_wait", 0, 0, 1, 1, 0);
        set_red(1'b0);
        cyc();
        set_red(1'b1);
        step("t1_walk", 0, 1, 0, 0, 0);
        step("t1_walk_tick", 1, 1, 0, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        expect_out("reset_async", 0, 1, 0, 0);
        check_out();
        cyc();
        rst = 1'b0;
        step("post_reset", 0, 0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
